// File: rtl/vx_mem_load_packer.sv
// Packs a stream of 32-bit instruction/data words into padded L1 cachelines
// and hands them to the memory loader through a small in-order line FIFO.
`ifndef L1_LINE_SIZE
`define L1_LINE_SIZE 64
`endif

module vx_mem_load_packer #(
  parameter int          LINE_SIZE  = `L1_LINE_SIZE,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] INST_PAD   = 32'h0000_0013,
  parameter logic [31:0] DATA_PAD   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   word_valid,
  output logic                   word_ready,
  input  logic [31:0]            word_data,
  input  logic                   word_type,
  input  logic                   word_last,
  output logic                   load_valid,
  input  logic                   load_ready,
  output logic                   data_type,
  output logic [LINE_SIZE*8-1:0] cacheline,
  output logic [31:0]            inst_line_count,
  output logic [31:0]            data_line_count,
  output logic                   idle
);

  localparam int WORD_WIDTH = 32;
  localparam int WORDS      = LINE_SIZE / 4;
  localparam int IDX_W      = $clog2(WORDS);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {FILL, FLUSH} state_e;

  typedef struct packed {
    logic                   typ;
    logic [LINE_SIZE*8-1:0] line;
  } entry_t;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        widx;
  logic                    line_type;
  logic [WORD_WIDTH-1:0]   asm_words [WORDS];
  entry_t                  fifo_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_count;

  logic                    has_room, type_mismatch, flush_push;
  logic                    word_accept, push, pop;
  logic                    close_type;
  logic [WORD_WIDTH-1:0]   pad_word;
  logic [LINE_SIZE*8-1:0]  close_line;

  assign has_room      = fifo_count < CNT_W'(FIFO_DEPTH);
  assign type_mismatch = word_valid && (widx != '0) && (word_type != line_type);

  // A type change with room in the FIFO flushes the partial line on the spot,
  // costing one stall cycle; FLUSH is only parked in while the FIFO is full.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d    = state_q;
    word_ready = 1'b0;
    flush_push = 1'b0;
    case (state_q)
      FILL: begin
        if (!reset && type_mismatch) begin
          if (has_room) flush_push = 1'b1;
          else          state_d    = FLUSH;
        end else if (!reset && has_room) begin
          word_ready = 1'b1;
        end
      end
      FLUSH: begin
        if (has_room) begin
          flush_push = 1'b1;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign word_accept = word_valid && word_ready;
  assign push        = flush_push ||
                       (word_accept && (word_last || widx == IDX_W'(WORDS - 1)));
  assign pop         = load_valid && load_ready;

  // Closed line: stored words, then the incoming word (unless flushing), then padding.
  always_comb begin
    close_type = (widx == '0) ? word_type : line_type;
    pad_word   = close_type ? DATA_PAD : INST_PAD;
    close_line = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (i < int'(widx))
        close_line[i*WORD_WIDTH +: WORD_WIDTH] = asm_words[i];
      else if (i == int'(widx) && !flush_push)
        close_line[i*WORD_WIDTH +: WORD_WIDTH] = word_data;
      else
        close_line[i*WORD_WIDTH +: WORD_WIDTH] = pad_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FILL;
      widx            <= '0;
      line_type       <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      inst_line_count <= '0;
      data_line_count <= '0;
      // NOTE: the FIFO entries are reset because they drive cacheline directly,
      // which must read zero out of reset; the assembly buffer needs no reset.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      state_q <= state_d;

      if (push)             widx <= '0;
      else if (word_accept) widx <= widx + IDX_W'(1);

      if (word_accept && widx == '0) line_type <= word_type;

      if (push) begin
        fifo_mem[wr_ptr] <= '{typ: close_type, line: close_line};
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        if (data_type) data_line_count <= data_line_count + 32'd1;
        else           inst_line_count <= inst_line_count + 32'd1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (word_accept) asm_words[widx] <= word_data;
  end

  assign load_valid = (fifo_count != '0);
  assign cacheline  = fifo_mem[rd_ptr].line;
  assign data_type  = fifo_mem[rd_ptr].typ;
  assign idle       = (widx == '0) && (fifo_count == '0) && (state_q == FILL);

endmodule

// File: doc/vx_mem_load_packer.md
Name: vx_mem_load_packer

Overview:
Upstream feeder of the memory loader. It takes a stream of 32-bit RISC-V instruction or data words from the testbench driver and packs them into full L1 cachelines. It presents each line, with its type (INST/DATA), on the slave side of VX_mem_load_if (this block drives the master side). A 2-entry output FIFO decouples word assembly from loader backpressure.

Parameters:
LINE_SIZE, `L1_LINE_SIZE (64), cacheline size in bytes; WORDS = LINE_SIZE/4
WORD_WIDTH, 32, input word width; fixed, not overridable
FIFO_DEPTH, 2, completed-line buffer entries
INST_PAD, 32'h00000013, fill word for partial INST lines (RISC-V NOP)
DATA_PAD, 32'h00000000, fill word for partial DATA lines

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
word_valid  in  1  input word present
word_ready  out  1  packer accepts word this cycle
word_data  in  32  instruction/data word
word_type  in  1  INST=0, DATA=1 (same encoding as data_type)
word_last  in  1  close current line after this word
load_valid  out  1  cacheline presented to loader
load_ready  in  1  loader accepts cacheline
data_type  out  1  type of presented line
cacheline  out  LINE_SIZE*8  presented line (risc_v_cacheline_t)
inst_line_count  out  32  INST lines handed off since reset
data_line_count  out  32  DATA lines handed off since reset
idle  out  1  assembly buffer empty, FIFO empty, state FILL

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: load_valid=0, word_ready=0 during reset, cacheline=0, data_type=INST, both counts=0, idle=1, state=FILL, word index=0, FIFO empty.
- Handshakes:
  - Word transfer occurs when word_valid && word_ready.
  - Line transfer occurs when load_valid && load_ready.
  - While load_valid=1 and load_ready=0, cacheline and data_type are held stable.
- Packing:
  - Word index widx counts 0..WORDS-1.
  - An accepted word is written to bits [32*widx +: 32], so word 0 sits in the LSBs.
  - The line type is latched from the first word of the line.
- Line close: on acceptance of word WORDS-1, or of any word with word_last=1.
  - Unfilled slots are padded: INST_PAD for INST lines, DATA_PAD for DATA lines.
  - The line is pushed into the FIFO at that same clock edge and widx returns to 0.
- Output latency: load_valid is asserted on the cycle after the closing edge when the FIFO was empty. load_valid and the line outputs are driven from registers, with no combinational path from word inputs.
- word_ready = (state==FILL) && (fifo_count < FIFO_DEPTH). This does not depend on load_ready, so a pop and a push in the same cycle are both legal.
- States:
  - FILL: normal packing.
  - FLUSH: entered when word_valid=1, widx>0, and word_type differs from the latched line type.
    - word_ready=0 in that cycle and the word is not consumed.
    - In FLUSH, the partial line is padded per its own type and pushed once fifo_count<FIFO_DEPTH.
    - Then return to FILL; the waiting word starts a new line the following cycle.
- Counters: on each line transfer, increment inst_line_count or data_line_count by data_type; both wrap at 2^32.
- FIFO order is strict in-order; a line is never dropped or duplicated.
- word_last with widx==WORDS-1 closes exactly one line; no empty line is ever emitted.
- Reset mid-operation: the partial line and FIFO contents are discarded, counts are zeroed, and the next accepted word goes to slot 0.

Test Plan:
- 16 INST words 0x100..0x10F, load_ready=1 → one line, bits[31:0]=0x100, bits[511:480]=0x10F, data_type=INST, load_valid high 1 cycle after 16th word accepted, inst_line_count=1.
- 3 DATA words 0xA,0xB,0xC, word_last on 3rd → line words0..2=0xA/0xB/0xC, words3..15=0, data_type=DATA, data_line_count=1.
- 5 INST words, then a DATA word (no last) → word_ready low exactly 1 cycle; first line words5..15=0x00000013 (INST); DATA word lands in slot 0 of the next line.
- load_ready=0, stream 48 INST words → word_ready drops after 32nd word (2 lines buffered); line 1 held stable; raising load_ready releases lines in order 1,2,3; inst_line_count=3.
- Pop and push in the same cycle with FIFO full → no stall beyond the word_ready rule, no lost line, counts correct.
- reset asserted after 7 words of a line → next cycle load_valid=0, idle=1, counts=0; next 16 words form a clean line starting at slot 0.
